// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS.cc countdown timer with four push-buttons.
//   CLOCK_50 : system clock, all state on the rising edge
//   RST_N    : asynchronous reset, active low
//   KEY[3:0] : raw buttons, active low: [0] start/pause, [1] clear,
//              [2] +1 min, [3] +10 s
//   TIME_BCD : {m_t, m_o, s_t, s_o, c_t, c_o}; preset in IDLE, count otherwise
//   STATE    : 0=IDLE 1=RUN 2=PAUSE 3=DONE
//   ALARM    : high while in DONE
// Each key runs through its own synchronizer/debouncer lane. A lane emits a
// one-cycle press pulse on an accepted 1->0 level change. Every output comes
// straight from a flop.

// Per-key lane: 2-flop synchronizer, debounce counter and press pulse.
module countdown_timer_key #(
  parameter int DB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic key_raw,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronized samples that differ from the
  // accepted level. The input is binary, so these samples all match each
  // other. A sample equal to the accepted level restarts the run.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module countdown_timer #(
  parameter int DIV       = 500000,
  parameter int DB_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic [3:0]  KEY,
  output logic [23:0] TIME_BCD,
  output logic [1:0]  STATE,
  output logic        ALARM
);
  typedef struct packed {
    logic [3:0] m_t, m_o, s_t, s_o, c_t, c_o;
  } bcd_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} st_t;

  localparam int   PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam bcd_t RST_TIME = bcd_t'(24'h010000);

  logic [3:0]    press;
  st_t           state, state_nxt;
  bcd_t          preset, preset_nxt;
  bcd_t          count, count_nxt, count_dec;
  logic [PW-1:0] presc, presc_nxt;
  logic          tick;

  countdown_timer_key #(.DB_CYCLES(DB_CYCLES)) u_key [3:0] (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .key_raw  (KEY),
    .press    (press)
  );

  // Decrement by one centisecond with BCD borrow through every digit.
  function automatic bcd_t bcd_dec(input bcd_t t);
    bcd_t r;
    r = t;
    if (t.c_o != 4'd0) r.c_o = t.c_o - 4'd1;
    else begin
      r.c_o = 4'd9;
      if (t.c_t != 4'd0) r.c_t = t.c_t - 4'd1;
      else begin
        r.c_t = 4'd9;
        if (t.s_o != 4'd0) r.s_o = t.s_o - 4'd1;
        else begin
          r.s_o = 4'd9;
          if (t.s_t != 4'd0) r.s_t = t.s_t - 4'd1;
          else begin
            r.s_t = 4'd5;
            if (t.m_o != 4'd0) r.m_o = t.m_o - 4'd1;
            else begin
              r.m_o = 4'd9;
              r.m_t = (t.m_t != 4'd0) ? t.m_t - 4'd1 : 4'd5;
            end
          end
        end
      end
    end
    return r;
  endfunction

  assign count_dec = bcd_dec(count);

  // Next-state logic. The key-priority chain (1 > 0 > 2 > 3) is expressed
  // by the if/else ordering. Inside RUN a start/pause or clear event takes
  // the cycle, so a coincident tick is dropped.
  always_comb begin
    state_nxt  = state;
    preset_nxt = preset;
    count_nxt  = count;
    presc_nxt  = presc;
    tick       = 1'b0;

    if (state == RUN) begin
      tick      = (presc == PW'(DIV - 1));
      presc_nxt = tick ? '0 : presc + 1'b1;
    end

    case (state)
      IDLE: begin
        if (press[1]) begin
          preset_nxt = '0;
        end else if (press[0]) begin
          if (preset != '0) begin
            count_nxt = preset;
            presc_nxt = '0;
            state_nxt = RUN;
          end
        end else if (press[2]) begin
          if (preset.m_o == 4'd9) begin
            preset_nxt.m_o = 4'd0;
            preset_nxt.m_t = (preset.m_t == 4'd5) ? 4'd0 : preset.m_t + 4'd1;
          end else begin
            preset_nxt.m_o = preset.m_o + 4'd1;
          end
        end else if (press[3]) begin
          // +10 s wraps inside the tens digit; minutes are left alone.
          preset_nxt.s_t = (preset.s_t == 4'd5) ? 4'd0 : preset.s_t + 4'd1;
        end
      end
      RUN: begin
        if (press[1]) begin
          state_nxt = IDLE;
        end else if (press[0]) begin
          state_nxt = PAUSE;
        end else if (tick) begin
          count_nxt = count_dec;
          if (count_dec == '0) state_nxt = DONE;
        end
      end
      PAUSE: begin
        if (press[1])      state_nxt = IDLE;
        else if (press[0]) state_nxt = RUN;
      end
      DONE: begin
        if (press[1] || press[0]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The display and alarm registers load from next-state values, so they
  // change on the same edge as STATE.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      preset   <= RST_TIME;
      count    <= RST_TIME;
      presc    <= '0;
      TIME_BCD <= RST_TIME;
      ALARM    <= 1'b0;
    end else begin
      state    <= state_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      presc    <= presc_nxt;
      TIME_BCD <= (state_nxt == IDLE) ? preset_nxt : count_nxt;
      ALARM    <= (state_nxt == DONE);
    end
  end

  assign STATE = state;
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter DIV, default 500000, meaning clock cycles per 10 ms tick.
REQ-002 The block SHALL have parameter DB_CYCLES, default 500000, meaning consecutive stable samples needed to accept a key level.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port CLOCK_50  input  1  system clock; all state on its rising edge.
REQ-005 The block SHALL have port RST_N  input  1  asynchronous reset, active low.
REQ-006 The block SHALL have port KEY  input  4  raw push-buttons, active low: [0] start/pause, [1] clear, [2] +1 min, [3] +10 s.
REQ-007 The block SHALL have port TIME_BCD  output  24  BCD MM:SS.cc as {m_t, m_o, s_t, s_o, c_t, c_o}, 4 bits each.
REQ-008 The block SHALL have port STATE  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.
REQ-009 The block SHALL have port ALARM  output  1  high while in DONE.

Function
REQ-010 Each KEY bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each synchronized key SHALL be debounced: a new level is accepted only after DB_CYCLES consecutive identical samples; any mismatch restarts the count.
REQ-012 An accepted 1->0 transition SHALL produce a one-cycle press event; release produces no event.
REQ-013 Same-cycle events SHALL be resolved by priority KEY1 > KEY0 > KEY2 > KEY3; only the winner acts and the rest are discarded.
REQ-014 Preset register: minutes 00-59 and tens-of-seconds 0-5; preset cs and s_o are always 0.
REQ-015 IDLE: a KEY2 event SHALL add 1 minute, wrapping 59->00, and a KEY3 event SHALL add 10 s, wrapping 50->00, with no carry into minutes.
REQ-016 IDLE: a KEY1 event SHALL set preset to 00:00.00.
REQ-017 IDLE: a KEY0 event with nonzero preset SHALL load count=preset, clear the prescaler and enter RUN; a KEY0 event with zero preset is ignored.
REQ-018 Prescaler: counts 0..DIV-1 only in RUN, wraps to 0 and emits a tick, and holds its value in PAUSE.
REQ-019 RUN: each tick SHALL decrement count by 1 cs with BCD borrow (cs 00->99 borrows from s; s 00->59 borrows from min).
REQ-020 RUN: a tick that makes count 00:00.00 SHALL move to DONE and assert ALARM on that same edge.
REQ-021 RUN: a KEY0 event SHALL enter PAUSE, and a KEY1 event SHALL enter IDLE with preset unchanged.
REQ-022 RUN: a key event in the same cycle as a tick SHALL win and suppress that tick's decrement.
REQ-023 PAUSE: count and prescaler SHALL be frozen; KEY0 returns to RUN at the held prescaler phase, and KEY1 enters IDLE.
REQ-024 DONE: count holds 00:00.00 and ALARM=1; a KEY0 or KEY1 event enters IDLE and clears ALARM.
REQ-025 KEY2 and KEY3 events SHALL be ignored outside IDLE.
REQ-026 TIME_BCD SHALL show preset in IDLE and count in all other states.
REQ-027 All outputs SHALL be registered, with no combinational path from KEY.
REQ-028 Each BCD digit SHALL never leave its legal range (c 0-9, s_t/m_t 0-5, s_o/m_o 0-9).

Reset
REQ-029 With RST_N low, STATE SHALL be 0 and ALARM 0 immediately, without waiting for a clock edge.
REQ-030 With RST_N low, preset and count SHALL be 01:00.00 and TIME_BCD 0x010000.
REQ-031 With RST_N low, the prescaler and debounce counters SHALL be 0, and the debounced key levels and synchronizers SHALL be 1 (released).
REQ-032 Operation SHALL resume on the first rising edge after RST_N deasserts.

Verification (DIV=4, DB_CYCLES=3)
REQ-033 Reset: after reset release, TIME_BCD=0x010000, STATE=0, ALARM=0.
REQ-034 Preset: 3 KEY2 presses -> 0x040000; then 7 KEY3 presses -> 0x041000 (seconds wrapped 50->00 with no minute carry).
REQ-035 Countdown: preset 00:10.00, press KEY0 -> STATE=1; first tick gives 0x000999; after 1000 ticks (4000 cycles) TIME_BCD=0, STATE=3, ALARM=1 on the same edge; KEY1 press -> STATE=0, ALARM=0, TIME_BCD=0x001000.
REQ-036 Pause: KEY0 during RUN -> count frozen for 400 cycles; second KEY0 resumes, and the next decrement occurs DIV minus held prescaler cycles later.
REQ-037 Debounce/priority: KEY0 low for 2 cycles -> no event; KEY0 and KEY1 accepted in the same cycle during RUN -> STATE=0; KEY0 with preset 00:00.00 -> STATE stays 0.
REQ-038 Async reset: RST_N pulsed low mid-RUN between clock edges -> STATE=0 and TIME_BCD=0x010000 before the next edge.
